// File: rtl/sha256_block_loader_if.sv
// Interface bundle for sha256_block_loader.
// Groups the request inputs, the memory read port and the block output
// handshake of the loader.
//   start, message_addr, nonce  : load request (host -> loader)
//   mem_addr, mem_we            : memory read address / write enable (loader -> memory)
//   mem_read_data               : synchronous read data (memory -> loader)
//   blk_data, blk_valid, blk_last, blk_ready : padded block handshake
//   busy, done                  : status
// Modports: slave = the loader itself, master = the host/memory/hasher side.
interface sha256_block_loader_if;
    logic        start;
    logic [15:0] message_addr;
    logic [31:0] nonce;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_read_data;
    logic [31:0] blk_data [16];
    logic        blk_valid;
    logic        blk_ready;
    logic        blk_last;
    logic        busy;
    logic        done;

    modport slave (
        input  start, message_addr, nonce, mem_read_data, blk_ready,
        output mem_addr, mem_we, blk_data, blk_valid, blk_last, busy, done
    );

    modport master (
        output start, message_addr, nonce, mem_read_data, blk_ready,
        input  mem_addr, mem_we, blk_data, blk_valid, blk_last, busy, done
    );
endinterface

// File: rtl/sha256_block_loader.sv
// sha256_block_loader
// Reads a MSG_WORDS-word message from a synchronous-read memory, substitutes
// word NONCE_IDX with a sampled nonce, and presents the SHA-256 padded stream
// one 16-word block at a time over a valid/ready handshake.
// Ports:
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : sha256_block_loader_if.slave (request, memory port, block
//              handshake, busy/done status)
module sha256_block_loader #(
    parameter int MSG_WORDS = 20,
    parameter int NONCE_IDX = 19
) (
    input  logic                    clk,
    input  logic                    reset_n,
    sha256_block_loader_if.slave    bus
);

    localparam int          NB        = (MSG_WORDS + 18) / 16;
    localparam logic [31:0] MSG_LEN   = 32'(MSG_WORDS);
    localparam logic [31:0] NONCE_POS = 32'(NONCE_IDX);
    localparam logic [31:0] LEN_POS   = 32'(16 * NB - 1);
    localparam logic [31:0] BIT_LEN   = 32'(MSG_WORDS * 32);
    localparam logic [6:0]  LAST_BLK  = 7'(NB - 1);

    typedef enum logic [1:0] {IDLE, FETCH, PRESENT, FINISH} state_t;

    state_t      state_reg, state_next;
    logic [15:0] base_reg;
    logic [31:0] nonce_reg;
    logic [6:0]  blk_reg;
    logic [4:0]  cnt_reg;
    logic [15:0] mem_addr_reg;
    logic        blk_last_reg;
    logic [31:0] blk_data_reg [16];

    // Stream position of word 0 of the current block, and how many of its
    // words come from the message (0..16).
    logic [31:0] pos_base;
    logic [31:0] remaining;
    logic [4:0]  blk_words;
    logic [31:0] cur_pos;
    logic [15:0] fetch_addr;
    logic        fetch_rd;
    logic        fetch_last;

    always_comb begin
        pos_base   = {21'd0, blk_reg, 4'd0};
        remaining  = (MSG_LEN > pos_base) ? (MSG_LEN - pos_base) : 32'd0;
        blk_words  = (remaining >= 32'd16) ? 5'd16 : remaining[4:0];
        cur_pos    = pos_base + {27'd0, cnt_reg};
        fetch_addr = base_reg + pos_base[15:0] + {11'd0, cnt_reg};
        // The nonce word is never read from memory; the address simply holds.
        fetch_rd   = (state_reg == FETCH) && (cnt_reg < blk_words) && (cur_pos != NONCE_POS);
        fetch_last = (cnt_reg == blk_words);
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and status outputs
    always_comb begin
        state_next    = state_reg;
        bus.busy      = (state_reg != IDLE);
        bus.done      = 1'b0;
        bus.blk_valid = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (fetch_last) begin
                    state_next = PRESENT;
                end
            end
            PRESENT: begin
                bus.blk_valid = 1'b1;
                if (bus.blk_ready) begin
                    state_next = blk_last_reg ? FINISH : FETCH;
                end
            end
            FINISH: begin
                bus.done   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Control datapath
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_reg     <= 16'd0;
            nonce_reg    <= 32'd0;
            blk_reg      <= 7'd0;
            cnt_reg      <= 5'd0;
            mem_addr_reg <= 16'd0;
            blk_last_reg <= 1'b0;
        end else begin
            if (fetch_rd) begin
                mem_addr_reg <= fetch_addr;
            end
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        base_reg     <= bus.message_addr;
                        nonce_reg    <= bus.nonce;
                        blk_reg      <= 7'd0;
                        cnt_reg      <= 5'd0;
                        blk_last_reg <= 1'b0;
                    end
                end
                FETCH: begin
                    if (fetch_last) begin
                        cnt_reg      <= 5'd0;
                        blk_last_reg <= (blk_reg == LAST_BLK);
                    end else begin
                        cnt_reg <= cnt_reg + 5'd1;
                    end
                end
                PRESENT: begin
                    if (bus.blk_ready) begin
                        blk_last_reg <= 1'b0;
                        blk_reg      <= blk_reg + 7'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.mem_addr = fetch_rd ? fetch_addr : mem_addr_reg;
    assign bus.mem_we   = 1'b0;
    assign bus.blk_last = blk_last_reg;

    // Per-word block register. Padding and nonce words are loaded in the
    // first FETCH cycle; message word gi is captured in FETCH cycle gi+1,
    // when the data for the address issued in cycle gi is on mem_read_data.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_word
            logic [31:0] word_pos;
            logic        is_msg;
            logic        is_nonce;
            logic        load_const;
            logic        capture;
            logic [31:0] const_val;

            always_comb begin
                word_pos   = pos_base + 32'(gi);
                is_msg     = (word_pos < MSG_LEN);
                is_nonce   = is_msg && (word_pos == NONCE_POS);
                load_const = (state_reg == FETCH) && (cnt_reg == 5'd0) && (!is_msg || is_nonce);
                capture    = (state_reg == FETCH) && (cnt_reg == 5'(gi + 1)) && is_msg && !is_nonce;
                if (is_nonce) begin
                    const_val = nonce_reg;
                end else if (word_pos == MSG_LEN) begin
                    const_val = 32'h8000_0000;
                end else if (word_pos == LEN_POS) begin
                    const_val = BIT_LEN;
                end else begin
                    const_val = 32'd0;
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    blk_data_reg[gi] <= 32'd0;
                end else if (load_const) begin
                    blk_data_reg[gi] <= const_val;
                end else if (capture) begin
                    blk_data_reg[gi] <= bus.mem_read_data;
                end
            end

            assign bus.blk_data[gi] = blk_data_reg[gi];
        end
    endgenerate

endmodule

// File: doc/sha256_block_loader.md
SHA256_BLOCK_LOADER -- requirements
Module: sha256_block_loader

Interface
REQ-001 The module SHALL have parameter MSG_WORDS, default 20, giving the message length in 32-bit words (1..1000).
REQ-002 The module SHALL have parameter NONCE_IDX, default 19, giving the message word index replaced by the nonce input; NONCE_IDX >= MSG_WORDS disables replacement.
REQ-003 The module SHALL have port clk, input, 1, rising-edge clock.
REQ-004 The module SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 The module SHALL have port start, input, 1, single-cycle request to load a message.
REQ-006 The module SHALL have port message_addr, input, 16, word address of message word 0, sampled on accepted start.
REQ-007 The module SHALL have port nonce, input, 32, nonce value sampled on accepted start.
REQ-008 The module SHALL have port mem_addr, output, 16, memory read word address.
REQ-009 The module SHALL have port mem_we, output, 1, memory write enable, constant 0.
REQ-010 The module SHALL have port mem_read_data, input, 32, synchronous-read data, valid the cycle after its address.
REQ-011 The module SHALL have port blk_data, output, 16x32 unpacked array, padded block word 0..15.
REQ-012 The module SHALL have port blk_valid, output, 1, blk_data holds a complete block.
REQ-013 The module SHALL have port blk_ready, input, 1, downstream hasher accepts the block.
REQ-014 The module SHALL have port blk_last, output, 1, the presented block is the final block.
REQ-015 The module SHALL have port busy, output, 1, high in every state except IDLE.
REQ-016 The module SHALL have port done, output, 1, one-cycle pulse after the final block handshake.

Function
REQ-017 NB SHALL be (MSG_WORDS+18)/16 (integer division): MSG_WORDS=20 gives 2, 13 gives 1, 16 gives 2.
REQ-018 The padded stream word p SHALL be: message[p] for p<MSG_WORDS; 32'h80000000 for p==MSG_WORDS; MSG_WORDS*32 (truncated to 32 bits) for p==16*NB-1; 0 otherwise.
REQ-019 message[NONCE_IDX] SHALL be replaced by the sampled nonce; memory SHALL NOT be read for that word.
REQ-020 The FSM SHALL have states IDLE, FETCH, PRESENT, FINISH.
REQ-021 IDLE: start=1 SHALL sample message_addr and nonce, clear the block counter, and go to FETCH; start outside IDLE SHALL be ignored.
REQ-022 FETCH: in its k-th cycle (k=0..n-1), the block SHALL drive mem_addr=message_addr+16*blk+k, where n is the number of message words in the current block (0..16).
REQ-023 FETCH: data for address k SHALL be written to blk_data[k] in cycle k+1; FETCH SHALL last exactly n+1 cycles (1 cycle when n=0); all non-message words SHALL be loaded per REQ-018 during the same interval.
REQ-024 On leaving FETCH the block SHALL enter PRESENT with blk_valid=1 and blk_last=(blk==NB-1).
REQ-025 PRESENT: blk_data, blk_valid and blk_last SHALL stay stable while blk_ready=0.
REQ-026 PRESENT: blk_valid & blk_ready SHALL drop blk_valid the next cycle, then go to FETCH with blk+1 if not last, otherwise to FINISH.
REQ-027 FINISH: done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-028 blk_ready asserted while blk_valid=0 SHALL have no effect.
REQ-029 mem_addr SHALL wrap modulo 2^16.
REQ-030 mem_addr SHALL hold its last value outside FETCH.

Reset
REQ-031 reset_n=0 SHALL immediately force state IDLE, blk_valid=0, blk_last=0, done=0, busy=0, mem_we=0, mem_addr=0, and all blk_data words to 0.
REQ-032 Reset asserted mid-fetch or mid-present SHALL abandon the message; after release no block SHALL be presented until a new start.

Verification
REQ-033 Defaults, message_addr=0x0100, mem[0x100+i]=i+1, nonce=0xDEADBEEF, blk_ready=1 -> block0 words 1..16; block1 = {17,18,19,0xDEADBEEF,0x80000000,0,...,0,0x00000280}; blk_last only on block1; done 1 cycle later.
REQ-034 Timing with defaults -> block0 blk_valid at cycle 17 after start acceptance; 16 sequential mem_addr values 0x0100..0x010F.
REQ-035 Backpressure: blk_ready=0 for 10 cycles on block0 -> blk_data and blk_valid held constant; no mem_addr change; handshake on cycle 11.
REQ-036 Wrap-around: MSG_WORDS=13, message_addr=0xFFFE -> one block; addresses FFFE, FFFF, 0000..000A; word13=0x80000000, word15=0x000001A0.
REQ-037 Reset: reset_n pulsed low during block1 FETCH -> all outputs 0 at once; start ignored while busy; new start after reset produces a correct block0.
REQ-038 Exact fill: MSG_WORDS=16, NONCE_IDX=20 -> block1 has FETCH of 1 cycle and contents {0x80000000,0,...,0,0x00000200}.
